// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: PC register, branch-target table, run/halt sequencing and saturating cycle counter
module fetch_pc_unit #(
   parameter int PC_W = 10,
   parameter int LUT_DEPTH = 16,
   parameter int CNT_W = 16,
   localparam int IDX_W = $clog2(LUT_DEPTH)
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic             i_start,
   input  logic [PC_W-1:0]  i_start_addr,
   input  logic             i_branch,
   input  logic [7:0]       i_alu_out,
   input  logic [IDX_W-1:0] i_lut_idx,
   input  logic             i_halt_req,
   input  logic             i_stall,
   input  logic             i_lut_we,
   input  logic [IDX_W-1:0] i_lut_waddr,
   input  logic [PC_W-1:0]  i_lut_wdata,
   output logic [PC_W-1:0]  o_pc,
   output logic             o_pc_valid,
   output logic             o_done,
   output logic [CNT_W-1:0] o_cycle_count
);
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED} state_t;
   state_t           r_state;
   logic [PC_W-1:0]  r_lut [LUT_DEPTH];
   logic             w_taken;
   logic             w_unused;
   assign w_taken  = i_branch & i_alu_out[0];
   assign w_unused = ^i_alu_out[7:1];
   // branch-target table, writable only while idle so a running program sees stable targets
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         for (int i = 0; i < LUT_DEPTH; i++) r_lut[i] <= '0;
      end else if (r_state == S_IDLE && i_lut_we) begin
         r_lut[i_lut_waddr] <= i_lut_wdata;
      end
   end
   // control FSM with registered PC, valid, done and cycle counter
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state       <= S_IDLE;
         o_pc          <= '0;
         o_pc_valid    <= 1'b0;
         o_done        <= 1'b0;
         o_cycle_count <= '0;
      end else if (i_start) begin
         r_state       <= S_RUN;
         o_pc          <= i_start_addr;
         o_pc_valid    <= 1'b1;
         o_done        <= 1'b0;
         o_cycle_count <= '0;
      end else if (r_state == S_RUN) begin
         if (i_halt_req) begin
            r_state    <= S_HALTED;
            o_pc_valid <= 1'b0;
            o_done     <= 1'b1;
         end else begin
            o_cycle_count <= (&o_cycle_count) ? o_cycle_count : o_cycle_count + CNT_W'(1);
            if (!i_stall) o_pc <= w_taken ? r_lut[i_lut_idx] : o_pc + PC_W'(1);
         end
      end
   end
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: directed checks of fetch_pc_unit with a 4-bit-counter instance for saturation
module tb_fetch_pc_unit;
   logic        clk = 1'b0;
   logic        rst_n, start, branch, halt_req, stall, lut_we;
   logic [9:0]  start_addr, lut_wdata;
   logic [7:0]  alu_out;
   logic [3:0]  lut_idx, lut_waddr;
   logic [9:0]  pc, pc_s;
   logic        valid, done, valid_s, done_s;
   logic [15:0] cnt;
   logic [3:0]  cnt_s;
   int          total = 0, bad = 0;

   always #5 clk = ~clk;

   fetch_pc_unit u_dut (
      .i_clk(clk), .i_reset_n(rst_n), .i_start(start), .i_start_addr(start_addr),
      .i_branch(branch), .i_alu_out(alu_out), .i_lut_idx(lut_idx), .i_halt_req(halt_req),
      .i_stall(stall), .i_lut_we(lut_we), .i_lut_waddr(lut_waddr), .i_lut_wdata(lut_wdata),
      .o_pc(pc), .o_pc_valid(valid), .o_done(done), .o_cycle_count(cnt)
   );

   fetch_pc_unit #(.CNT_W(4)) u_sat (
      .i_clk(clk), .i_reset_n(rst_n), .i_start(start), .i_start_addr(start_addr),
      .i_branch(branch), .i_alu_out(alu_out), .i_lut_idx(lut_idx), .i_halt_req(halt_req),
      .i_stall(stall), .i_lut_we(lut_we), .i_lut_waddr(lut_waddr), .i_lut_wdata(lut_wdata),
      .o_pc(pc_s), .o_pc_valid(valid_s), .o_done(done_s), .o_cycle_count(cnt_s)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; start = 0; branch = 0; halt_req = 0; stall = 0; lut_we = 0;
      start_addr = '0; lut_wdata = '0; alu_out = '0; lut_idx = '0; lut_waddr = '0;
      #2;
      chk("rst_pc", pc, 0);
      chk("rst_valid", valid, 0);
      chk("rst_done", done, 0);
      chk("rst_cnt", cnt, 0);
      #10 rst_n = 1'b1;
      tick();
      // test 1: table write in IDLE, start, sequential fetch
      lut_we = 1; lut_waddr = 3; lut_wdata = 10'h040;
      tick();
      lut_we = 0;
      chk("idle_pc_hold", pc, 0);
      chk("idle_valid", valid, 0);
      start = 1; start_addr = 10'h010;
      tick();
      start = 0;
      chk("start_pc", pc, 10'h010);
      chk("start_valid", valid, 1);
      chk("start_cnt", cnt, 0);
      for (int i = 1; i <= 5; i++) begin
         tick();
         chk("seq_pc", pc, 10'h010 + i);
      end
      chk("seq_cnt", cnt, 5);
      // test 2: branch taken then not taken, both from 0x012
      start = 1; start_addr = 10'h012;
      tick();
      start = 0; branch = 1; lut_idx = 3; alu_out = 8'h01;
      tick();
      chk("br_taken", pc, 10'h040);
      start = 1; start_addr = 10'h012; branch = 0;
      tick();
      start = 0; branch = 1; alu_out = 8'hFE;
      tick();
      chk("br_not_taken", pc, 10'h013);
      chk("br_cnt", cnt, 1);
      // test 3: stall then halt with stall and branch also asserted
      branch = 0; alu_out = 0; stall = 1;
      tick();
      chk("stall1_pc", pc, 10'h013);
      chk("stall1_cnt", cnt, 2);
      tick();
      chk("stall2_pc", pc, 10'h013);
      chk("stall2_cnt", cnt, 3);
      halt_req = 1; branch = 1; alu_out = 8'h01;
      tick();
      halt_req = 0; branch = 0; stall = 0; alu_out = 0;
      chk("halt_done", done, 1);
      chk("halt_valid", valid, 0);
      chk("halt_pc", pc, 10'h013);
      chk("halt_cnt", cnt, 3);
      lut_we = 1; lut_waddr = 3; lut_wdata = 10'h100;
      tick();
      lut_we = 0;
      tick();
      chk("halted_pc_frozen", pc, 10'h013);
      chk("halted_cnt_frozen", cnt, 3);
      chk("halted_done", done, 1);
      // test 4: restart from HALTED with PC wrap
      start = 1; start_addr = 10'h3FE;
      tick();
      start = 0;
      chk("restart_done", done, 0);
      chk("restart_valid", valid, 1);
      chk("restart_pc", pc, 10'h3FE);
      chk("restart_cnt", cnt, 0);
      tick();
      chk("wrap_pc0", pc, 10'h3FF);
      tick();
      chk("wrap_pc1", pc, 10'h000);
      chk("wrap_cnt", cnt, 2);
      // test 5: table write during RUN ignored, then async reset mid-cycle
      lut_we = 1; lut_waddr = 3; lut_wdata = 10'h200;
      tick();
      lut_we = 0;
      chk("run_we_pc", pc, 10'h001);
      branch = 1; lut_idx = 3; alu_out = 8'h01;
      tick();
      branch = 0; alu_out = 0;
      chk("old_target", pc, 10'h040);
      #2 rst_n = 1'b0;
      #1;
      chk("async_pc", pc, 0);
      chk("async_valid", valid, 0);
      chk("async_done", done, 0);
      chk("async_cnt", cnt, 0);
      #3 rst_n = 1'b1;
      tick();
      start = 1; start_addr = 10'h050;
      tick();
      start = 0; branch = 1; lut_idx = 3; alu_out = 8'h01;
      tick();
      branch = 0; alu_out = 0;
      chk("lut_cleared", pc, 0);
      // test 6: 4-bit counter saturates
      start = 1; start_addr = 10'h000;
      tick();
      start = 0;
      chk("sat_start", cnt_s, 0);
      for (int i = 0; i < 14; i++) tick();
      chk("sat_14", cnt_s, 14);
      tick();
      chk("sat_15", cnt_s, 15);
      for (int i = 0; i < 5; i++) tick();
      chk("sat_hold", cnt_s, 15);
      chk("wide_cnt_20", cnt, 20);
      chk("sat_pc", pc_s, 10'd20);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
